// File: rtl/val2_shift_engine.sv
// Multi-cycle operand-2 generator: decodes the shifter mode, then shifts up to STEP bits per cycle.
// Optional flush input is enabled with the VAL2_FLUSH_EN macro.
module val2_shift_engine #(
    parameter int DATA_W = 32,
    parameter int STEP   = 8,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic [11:0]       shift_operand,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [7:0]        val_rs,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
`ifdef VAL2_FLUSH_EN
    ,
    input  logic              flush
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] DATA_C = CNT_W'(DATA_W);
    localparam logic [7:0]       MASK8  = (DATA_W >= 256) ? 8'hFF : 8'(DATA_W - 1);

    localparam logic [1:0] OP_LSL = 2'd0;
    localparam logic [1:0] OP_LSR = 2'd1;
    localparam logic [1:0] OP_ASR = 2'd2;
    localparam logic [1:0] OP_ROR = 2'd3;

    state_t              r_state, w_next;
    logic [DATA_W-1:0]   r_val, r_result;
    logic [1:0]          r_op;
    logic                r_rrx, r_carry, r_carry_out;
    logic [CNT_W-1:0]    r_rem;

    logic [DATA_W-1:0]   w_start;
    logic [1:0]          w_op;
    logic                w_rrx, w_carry0;
    logic [CNT_W-1:0]    w_cnt, w_k;
    logic [7:0]          w_rot, w_rsmod, w_amt;
    logic [DATA_W:0]     w_step;
    logic                w_last, w_accept, w_flush;

    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [7:0] a);
        if (32'(a) >= DATA_W)
            return DATA_C;
        return CNT_W'(a);
    endfunction

    // One shifter step of k (1..STEP) positions; returns {carry, value}.
    function automatic logic [DATA_W:0] step_fn(input logic [DATA_W-1:0] v, input logic [1:0] op,
                                                input logic rrx, input logic cin,
                                                input logic [CNT_W-1:0] k);
        logic [DATA_W-1:0]        lo, hi, nv;
        logic signed [DATA_W-1:0] sv;
        lo = v >> (k - CNT_W'(1));
        hi = v >> (DATA_C - k);
        sv = $signed(v) >>> k;
        case (op)
            OP_LSL:  nv = v << k;
            OP_LSR:  nv = v >> k;
            OP_ASR:  nv = sv;
            default: nv = (v >> k) | (v << (DATA_C - k));
        endcase
        if (op == OP_ROR && rrx)
            return {v[0], cin, v[DATA_W-1:1]};
        if (op == OP_LSL)
            return {hi[0], nv};
        return {lo[0], nv};
    endfunction

`ifdef VAL2_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_accept  = in_valid && (r_state == S_IDLE) && !w_flush;
    assign w_k       = (r_rem > STEP_C) ? STEP_C : r_rem;
    assign w_step    = step_fn(r_val, r_op, r_rrx, r_carry, w_k);
    assign w_last    = (r_rem == w_k);
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign carry_out = r_carry_out;

    // Request decode: start value, operation, effective count and the count-0 carry.
    always_comb begin
        w_start  = val_rm;
        w_op     = OP_LSL;
        w_rrx    = 1'b0;
        w_cnt    = '0;
        w_carry0 = carry_in;
        w_rot    = {3'b000, shift_operand[11:8], 1'b0} & MASK8;
        w_rsmod  = val_rs & MASK8;
        w_amt    = {3'b000, shift_operand[11:7]};
        case (mode)
            2'b00: begin
                w_start = DATA_W'(shift_operand[7:0]);
                w_op    = OP_ROR;
                w_cnt   = CNT_W'(w_rot);
                if (shift_operand[11:8] != 4'd0 && w_rot == 8'd0)
                    w_carry0 = w_start[DATA_W-1];
            end
            2'b01: begin
                w_op = shift_operand[6:5];
                case (shift_operand[6:5])
                    OP_LSL:         w_cnt = clamp_cnt(w_amt);
                    OP_LSR, OP_ASR: w_cnt = (w_amt == 8'd0) ? DATA_C : clamp_cnt(w_amt);
                    default: begin
                        if (w_amt == 8'd0) begin
                            w_rrx = 1'b1;
                            w_cnt = CNT_W'(1);
                        end else begin
                            w_cnt = CNT_W'(w_amt & MASK8);
                            if ((w_amt & MASK8) == 8'd0)
                                w_carry0 = val_rm[DATA_W-1];
                        end
                    end
                endcase
            end
            2'b10: begin
                w_op = shift_operand[6:5];
                if (val_rs != 8'd0) begin
                    case (shift_operand[6:5])
                        OP_LSL, OP_LSR: begin
                            if (32'(val_rs) <= DATA_W) begin
                                w_cnt = CNT_W'(val_rs);
                            end else begin
                                w_start  = '0;
                                w_carry0 = 1'b0;
                            end
                        end
                        OP_ASR: begin
                            if (32'(val_rs) >= DATA_W) begin
                                w_start  = {DATA_W{val_rm[DATA_W-1]}};
                                w_carry0 = val_rm[DATA_W-1];
                            end else begin
                                w_cnt = CNT_W'(val_rs);
                            end
                        end
                        default: begin
                            if (w_rsmod == 8'd0)
                                w_carry0 = val_rm[DATA_W-1];
                            else
                                w_cnt = CNT_W'(w_rsmod);
                        end
                    endcase
                end
            end
            default: w_start = DATA_W'(shift_operand);
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = (w_cnt != '0) ? S_SHIFT : S_DONE;
            S_SHIFT: if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_flush)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Working datapath: loaded on accept, stepped while shifting.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_val   <= w_start;
            r_op    <= w_op;
            r_rrx   <= w_rrx;
            r_carry <= w_carry0;
            r_rem   <= w_cnt;
        end else if (r_state == S_SHIFT && !w_flush) begin
            r_val   <= w_step[DATA_W-1:0];
            r_carry <= w_step[DATA_W];
            r_rem   <= r_rem - w_k;
        end
    end

    // Output registers only change when an operation completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_carry_out <= 1'b0;
        end else if (w_accept && w_cnt == '0) begin
            r_result    <= w_start;
            r_carry_out <= w_carry0;
        end else if (r_state == S_SHIFT && w_last && !w_flush) begin
            r_result    <= w_step[DATA_W-1:0];
            r_carry_out <= w_step[DATA_W];
        end
    end

endmodule

// File: tb/tb_val2_shift_engine.sv
// Randomized self-checking bench for val2_shift_engine against an architectural shifter model.
// Builds with or without VAL2_FLUSH_EN.
module tb_val2_shift_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  mode = 2'd0;
    logic [11:0] shift_operand = 12'd0;
    logic [31:0] val_rm = 32'd0;
    logic [7:0]  val_rs = 8'd0;
    logic        carry_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        carry_out;
`ifdef VAL2_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = 32'd0;
    logic        last_c = 1'b0;

    val2_shift_engine #(.DATA_W(32), .STEP(8), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .shift_operand(shift_operand), .val_rm(val_rm), .val_rs(val_rs),
        .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out)
`ifdef VAL2_FLUSH_EN
        , .flush(flush)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic bitn(input logic [31:0] x, input int n);
        logic [31:0] t;
        t = x >> n;
        return t[0];
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} >> (n % 32);
        return t[31:0];
    endfunction

    // Architectural operand-2 rules, computed in one shot; latency from the effective count.
    task automatic model(input logic [1:0] m, input logic [11:0] so, input logic [31:0] rm,
                         input logic [7:0] rs, input logic ci,
                         output logic [31:0] r, output logic c, output int lat);
        int          cnt, amt, a, n;
        logic [63:0] sext, t;
        sext = {{32{rm[31]}}, rm};
        cnt = 0; r = rm; c = ci;
        case (m)
            2'd0: begin
                n = 2 * int'(so[11:8]);
                r = ror32({24'd0, so[7:0]}, n);
                c = (n == 0) ? ci : r[31];
                cnt = n;
            end
            2'd1: begin
                amt = int'(so[11:7]);
                case (so[6:5])
                    2'd0: if (amt != 0) begin r = rm << amt; c = bitn(rm, 32 - amt); cnt = amt; end
                    2'd1: begin n = (amt == 0) ? 32 : amt; r = rm >> n; c = bitn(rm, n - 1); cnt = n; end
                    2'd2: begin
                        n = (amt == 0) ? 32 : amt;
                        t = sext >> n; r = t[31:0]; c = bitn(rm, n - 1); cnt = n;
                    end
                    default: begin
                        if (amt == 0) begin r = {ci, rm[31:1]}; c = rm[0]; cnt = 1; end
                        else begin r = ror32(rm, amt); c = r[31]; cnt = amt; end
                    end
                endcase
            end
            2'd2: begin
                a = int'(rs);
                if (a != 0) begin
                    case (so[6:5])
                        2'd0: begin
                            if (a < 32) begin r = rm << a; c = bitn(rm, 32 - a); cnt = a; end
                            else if (a == 32) begin r = 0; c = rm[0]; cnt = 32; end
                            else begin r = 0; c = 1'b0; end
                        end
                        2'd1: begin
                            if (a < 32) begin r = rm >> a; c = bitn(rm, a - 1); cnt = a; end
                            else if (a == 32) begin r = 0; c = rm[31]; cnt = 32; end
                            else begin r = 0; c = 1'b0; end
                        end
                        2'd2: begin
                            if (a >= 32) begin r = {32{rm[31]}}; c = rm[31]; end
                            else begin t = sext >> a; r = t[31:0]; c = bitn(rm, a - 1); cnt = a; end
                        end
                        default: begin
                            n = a % 32;
                            if (n == 0) begin r = rm; c = rm[31]; end
                            else begin r = ror32(rm, n); c = r[31]; cnt = n; end
                        end
                    endcase
                end
            end
            default: begin r = {20'd0, so}; c = ci; end
        endcase
        lat = 1 + (cnt + 7) / 8;
    endtask

    task automatic do_req(input string tag, input logic [1:0] m, input logic [11:0] so,
                          input logic [31:0] rm, input logic [7:0] rs, input logic ci, input int hold);
        logic [31:0] er;
        logic        ec;
        int          elat, lat;
        model(m, so, rm, rs, ci, er, ec, elat);
        @(negedge clk);
        mode = m; shift_operand = so; val_rm = rm; val_rs = rs; carry_in = ci; in_valid = 1'b1;
        chk({tag, "/in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        lat = 1;
        while (!out_valid && lat < 64) begin
            in_valid = 1'($urandom); mode = 2'($urandom); shift_operand = 12'($urandom);
            val_rm = $urandom; val_rs = 8'($urandom); carry_in = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "/out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "/latency"}, 64'(lat), 64'(elat));
        chk({tag, "/result"}, 64'(result), 64'(er));
        chk({tag, "/carry"}, 64'(carry_out), 64'(ec));
        chk({tag, "/busy"}, 64'(in_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom); val_rm = $urandom;
            @(posedge clk);
            #1;
            chk({tag, "/hold_result"}, 64'(result), 64'(er));
            chk({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "/hold_busy"}, 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "/release_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "/release_valid"}, 64'(out_valid), 64'd0);
        last_res = er; last_c = ec;
    endtask

    initial begin
        logic [31:0] rm;
        logic [7:0]  rs;
        int          stuck;

        repeat (3) @(posedge clk);
        #1;
        chk("reset/out_valid", 64'(out_valid), 64'd0);
        chk("reset/in_ready", 64'(in_ready), 64'd1);
        chk("reset/result", 64'(result), 64'd0);
        chk("reset/carry", 64'(carry_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_req("imm_rot", 2'b00, 12'h2FF, 32'h0, 8'd0, 1'b0, 0);
        do_req("lsr0", 2'b01, 12'h020, 32'h8000_0000, 8'd0, 1'b0, 0);
        do_req("rrx", 2'b01, 12'h060, 32'h0000_0003, 8'd0, 1'b1, 0);
        do_req("asr40", 2'b10, 12'h050, 32'h8000_0000, 8'd40, 1'b0, 0);
        do_req("lsl33", 2'b10, 12'h010, 32'hFFFF_FFFF, 8'd33, 1'b1, 0);
        do_req("lsl13", 2'b10, 12'h010, 32'h0000_0001, 8'd13, 1'b1, 0);
        do_req("ldst", 2'b11, 12'hABC, 32'h1234_5678, 8'd0, 1'b1, 3);
        do_req("lsl32", 2'b10, 12'h010, 32'h0000_0001, 8'd32, 1'b0, 0);
        do_req("lsr32", 2'b10, 12'h030, 32'h8000_0000, 8'd32, 1'b0, 0);
        do_req("ror32", 2'b10, 12'h070, 32'h8000_0001, 8'd64, 1'b0, 0);

        // Reset while shifting discards the operation.
        @(negedge clk);
        mode = 2'b01; shift_operand = 12'h020; val_rm = 32'hDEAD_BEEF; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid/pre_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid/in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid/out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid/result", 64'(result), 64'd0);
        stuck = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) stuck++;
        end
        chk("rst_mid/discarded", 64'(stuck), 64'd0);
        do_req("after_rst", 2'b10, 12'h050, 32'h8000_00F0, 8'd12, 1'b0, 1);

`ifdef VAL2_FLUSH_EN
        @(negedge clk);
        mode = 2'b01; shift_operand = 12'h020; val_rm = 32'h1357_9BDF; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush/in_ready", 64'(in_ready), 64'd1);
        chk("flush/out_valid", 64'(out_valid), 64'd0);
        chk("flush/result", 64'(result), 64'(last_res));
        chk("flush/carry", 64'(carry_out), 64'(last_c));
        do_req("after_flush", 2'b00, 12'h3A5, 32'h0, 8'd0, 1'b1, 0);
`endif

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: rm = 32'h8000_0000;
                1: rm = 32'hFFFF_FFFF;
                default: rm = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: rs = 8'($urandom);
                1: rs = 8'd32;
                default: rs = 8'($urandom_range(0, 40));
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req("rand", 2'($urandom), 12'($urandom), rm, rs, 1'($urandom), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
